// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master user interface among NUM_REQ requesters,
// one transaction in flight, with a watchdog that aborts hung transfers with SLVERR.
module axil_master_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                          rsp_error,
    output logic                                wr_valid,
    output logic [AXI_ADDR_WIDTH-1:0]           wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]           wr_data,
    input  logic                                wr_ready,
    input  logic                                wr_done,
    input  logic [1:0]                          wr_error,
    output logic                                rd_valid,
    output logic [AXI_ADDR_WIDTH-1:0]           rd_addr,
    input  logic                                rd_ready,
    input  logic                                rd_done,
    input  logic [AXI_DATA_WIDTH-1:0]           rd_data,
    input  logic [1:0]                          rd_error
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t                    state;
    logic [GW-1:0]             rr_ptr;
    logic [GW-1:0]             grant;
    logic [GW-1:0]             pick;
    logic [GW-1:0]             cand;
    logic                      any_req;
    logic                      lat_write;
    logic [AXI_ADDR_WIDTH-1:0] lat_addr;
    logic [AXI_DATA_WIDTH-1:0] lat_wdata;
    logic [TW-1:0]             timer;
    logic [TW-1:0]             timer_inc;
    logic                      timer_exp;
    logic                      abort;
    logic                      side_ready;
    logic                      side_done;
    logic [NUM_REQ-1:0]        pick_oh;
    logic [NUM_REQ-1:0]        grant_oh;
    logic [GW-1:0]             next_ptr;

    // First pending requester found scanning upward from rr_ptr with wrap-around.
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = GW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        side_ready = lat_write ? wr_ready : rd_ready;
        side_done  = lat_write ? wr_done  : rd_done;
        pick_oh    = NUM_REQ'(1) << pick;
        grant_oh   = NUM_REQ'(1) << grant;
        next_ptr   = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        timer_inc  = (timer == '1) ? timer : timer + 1'b1;
        timer_exp  = (timer == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            timer     <= '0;
            abort     <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_error <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            wr_valid  <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        lat_write <= req_write[pick];
                        lat_addr  <= req_addr[32'(pick)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        lat_wdata <= req_wdata[32'(pick)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                        req_ready <= pick_oh;
                        timer     <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (side_ready) begin
                        if (lat_write) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= lat_addr;
                            wr_data  <= lat_wdata;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_addr  <= lat_addr;
                        end
                        timer <= '0;
                        state <= S_WAIT;
                    end else if (timer_exp) begin
                        rsp_valid <= grant_oh;
                        rsp_error <= 2'b10;
                        rsp_rdata <= '0;
                        abort     <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                // rsp_valid is raised on the WAIT exit edge so it is visible one cycle after done.
                S_WAIT: begin
                    if (side_done) begin
                        rsp_valid <= grant_oh;
                        rsp_rdata <= lat_write ? '0 : rd_data;
                        rsp_error <= lat_write ? wr_error : rd_error;
                        state     <= S_RESP;
                    end else if (timer_exp) begin
                        rsp_valid <= grant_oh;
                        rsp_error <= 2'b10;
                        rsp_rdata <= '0;
                        abort     <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_RESP: begin
                    rr_ptr <= next_ptr;
                    state  <= abort ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (side_ready) begin
                        abort <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
